// File: rtl/sdram_wb_arbiter.sv
// rtl/sdram_wb_arbiter.sv - N-port Wishbone classic arbiter in front of one SDRAM controller port
// Round-robin or fixed priority, optional per-owner lock with hold window, and an ack timeout.
module sdram_wb_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int WB_ADDR_WIDTH = 24,
    parameter int WB_DATA_WIDTH = 16,
    parameter int ARB_MODE      = 0,
    parameter int MAX_LOCK      = 8,
    parameter int HOLD_WINDOW   = 4,
    parameter int ACK_TIMEOUT   = 256
) (
    input  logic                                     wb_clk_i,
    input  logic                                     wb_rst_ni,
    input  logic [NUM_PORTS-1:0]                     s_cyc_i,
    input  logic [NUM_PORTS-1:0]                     s_stb_i,
    input  logic [NUM_PORTS-1:0]                     s_we_i,
    input  logic [NUM_PORTS*WB_ADDR_WIDTH-1:0]       s_adr_i,
    input  logic [NUM_PORTS*WB_DATA_WIDTH-1:0]       s_dat_i,
    input  logic [NUM_PORTS*WB_DATA_WIDTH/8-1:0]     s_sel_i,
    output logic [NUM_PORTS*WB_DATA_WIDTH-1:0]       s_dat_o,
    output logic [NUM_PORTS-1:0]                     s_ack_o,
    output logic [NUM_PORTS-1:0]                     s_err_o,
    output logic                                     m_cyc_o,
    output logic                                     m_stb_o,
    output logic                                     m_we_o,
    output logic [WB_ADDR_WIDTH-1:0]                 m_adr_o,
    output logic [WB_DATA_WIDTH-1:0]                 m_dat_o,
    output logic [WB_DATA_WIDTH/8-1:0]               m_sel_o,
    input  logic [WB_DATA_WIDTH-1:0]                 m_dat_i,
    input  logic                                     m_ack_i,
    output logic [NUM_PORTS-1:0]                     grant_o,
    output logic [1:0]                               debug_state
);
    localparam int N  = NUM_PORTS;
    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int SW = WB_DATA_WIDTH / 8;
    localparam int IW = $clog2(N);
    localparam int LW = $clog2(MAX_LOCK + 1);
    localparam int HW = (HOLD_WINDOW > 0) ? $clog2(HOLD_WINDOW + 1) : 1;
    localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last_grant;
    logic [LW-1:0]   lock_cnt;
    logic [HW-1:0]   hold_cnt;
    logic [TW-1:0]   to_cnt;
    logic            err_flag;

    logic [N-1:0]    req;
    logic [IW-1:0]   win;
    logic [IW-1:0]   rr_idx;
    logic [IW-1:0]   src;
    logic            src_we;
    logic [AW-1:0]   src_adr;
    logic [DW-1:0]   src_dat;
    logic [SW-1:0]   src_sel;
    logic [N-1:0]    src_onehot;
    logic            own_cyc;
    logic            own_stb;

    assign req         = s_cyc_i & s_stb_i;
    assign debug_state = state;
    assign own_cyc     = |(s_cyc_i & grant_o);
    assign own_stb     = |(s_stb_i & grant_o);
    assign src         = (state == S_HOLD) ? owner : win;

    // Loops run from lowest to highest priority so the last hit is the winner.
    always_comb begin
        win    = '0;
        rr_idx = '0;
        if (ARB_MODE == 1) begin
            for (int j = N - 1; j >= 0; j--) begin
                if (req[j]) win = IW'(j);
            end
        end else begin
            for (int i = N; i >= 1; i--) begin
                rr_idx = IW'((int'(last_grant) + i) % N);
                for (int k = 0; k < N; k++) begin
                    if (rr_idx == IW'(k) && req[k]) win = IW'(k);
                end
            end
        end
    end

    always_comb begin
        src_we     = 1'b0;
        src_adr    = '0;
        src_dat    = '0;
        src_sel    = '0;
        src_onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (src == IW'(k)) begin
                src_we        = s_we_i[k];
                src_adr       = s_adr_i[k*AW +: AW];
                src_dat       = s_dat_i[k*DW +: DW];
                src_sel       = s_sel_i[k*SW +: SW];
                src_onehot[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= S_IDLE;
            owner      <= '0;
            last_grant <= IW'(N - 1);
            lock_cnt   <= '0;
            hold_cnt   <= '0;
            to_cnt     <= '0;
            err_flag   <= 1'b0;
            grant_o    <= '0;
            m_cyc_o    <= 1'b0;
            m_stb_o    <= 1'b0;
            m_we_o     <= 1'b0;
            m_adr_o    <= '0;
            m_dat_o    <= '0;
            m_sel_o    <= '0;
            s_dat_o    <= '0;
            s_ack_o    <= '0;
            s_err_o    <= '0;
        end else begin
            s_ack_o <= '0;
            s_err_o <= '0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        m_cyc_o    <= 1'b1;
                        m_stb_o    <= 1'b1;
                        m_we_o     <= src_we;
                        m_adr_o    <= src_adr;
                        m_dat_o    <= src_dat;
                        m_sel_o    <= src_sel;
                        grant_o    <= src_onehot;
                        owner      <= win;
                        last_grant <= win;
                        lock_cnt   <= LW'(1);
                        to_cnt     <= '0;
                        state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (m_ack_i) begin
                        m_cyc_o  <= 1'b0;
                        m_stb_o  <= 1'b0;
                        s_ack_o  <= grant_o;
                        err_flag <= 1'b0;
                        for (int k = 0; k < N; k++) begin
                            if (grant_o[k]) s_dat_o[k*DW +: DW] <= m_dat_i;
                        end
                        state    <= S_ACK;
                    end else if (ACK_TIMEOUT != 0 && to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                        m_cyc_o  <= 1'b0;
                        m_stb_o  <= 1'b0;
                        s_err_o  <= grant_o;
                        err_flag <= 1'b1;
                        state    <= S_ACK;
                    end else if (ACK_TIMEOUT != 0) begin
                        to_cnt   <= to_cnt + TW'(1);
                    end
                end
                S_ACK: begin
                    if (MAX_LOCK > 1 && lock_cnt < LW'(MAX_LOCK) && !err_flag && own_cyc) begin
                        hold_cnt <= '0;
                        state    <= S_HOLD;
                    end else begin
                        grant_o  <= '0;
                        state    <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    // Only the lock owner may issue here; last_grant is left alone.
                    if (own_cyc && own_stb) begin
                        m_cyc_o  <= 1'b1;
                        m_stb_o  <= 1'b1;
                        m_we_o   <= src_we;
                        m_adr_o  <= src_adr;
                        m_dat_o  <= src_dat;
                        m_sel_o  <= src_sel;
                        lock_cnt <= lock_cnt + LW'(1);
                        to_cnt   <= '0;
                        state    <= S_BUSY;
                    end else if (!own_cyc || HOLD_WINDOW <= 1 || hold_cnt == HW'(HOLD_WINDOW - 1)) begin
                        grant_o  <= '0;
                        state    <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// tb/tb_sdram_wb_arbiter.sv - scoreboard bench for sdram_wb_arbiter (round-robin and fixed-priority instances)
module tb_sdram_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        cyc [4];
    logic        stb [4];
    logic        we  [4];
    logic [23:0] adr [4];
    logic [15:0] wdat[4];

    logic [3:0]  s_cyc, s_stb, s_we;
    logic [95:0] s_adr;
    logic [63:0] s_dat;
    logic [7:0]  s_sel;
    assign s_sel = 8'hFF;

    always_comb begin
        s_cyc = '0; s_stb = '0; s_we = '0; s_adr = '0; s_dat = '0;
        for (int p = 0; p < 4; p++) begin
            s_cyc[p]            = cyc[p];
            s_stb[p]            = stb[p];
            s_we[p]             = we[p];
            s_adr[p*24 +: 24]   = adr[p];
            s_dat[p*16 +: 16]   = wdat[p];
        end
    end

    logic [63:0] sdo [2];
    logic [3:0]  sack[2], serr[2], gnt[2];
    logic [1:0]  dst [2];
    logic        mcyc[2], mstb[2], mwe[2], mack[2], stall[2];
    logic [23:0] madr[2];
    logic [15:0] mdo [2], mdi[2];
    logic [1:0]  msel[2];

    sdram_wb_arbiter #(.NUM_PORTS(4), .WB_ADDR_WIDTH(24), .WB_DATA_WIDTH(16), .ARB_MODE(0),
                       .MAX_LOCK(8), .HOLD_WINDOW(4), .ACK_TIMEOUT(16)) u_rr (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_we_i(s_we), .s_adr_i(s_adr), .s_dat_i(s_dat), .s_sel_i(s_sel),
        .s_dat_o(sdo[0]), .s_ack_o(sack[0]), .s_err_o(serr[0]),
        .m_cyc_o(mcyc[0]), .m_stb_o(mstb[0]), .m_we_o(mwe[0]), .m_adr_o(madr[0]), .m_dat_o(mdo[0]),
        .m_sel_o(msel[0]), .m_dat_i(mdi[0]), .m_ack_i(mack[0]),
        .grant_o(gnt[0]), .debug_state(dst[0]));

    sdram_wb_arbiter #(.NUM_PORTS(4), .WB_ADDR_WIDTH(24), .WB_DATA_WIDTH(16), .ARB_MODE(1),
                       .MAX_LOCK(8), .HOLD_WINDOW(4), .ACK_TIMEOUT(16)) u_fix (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_we_i(s_we), .s_adr_i(s_adr), .s_dat_i(s_dat), .s_sel_i(s_sel),
        .s_dat_o(sdo[1]), .s_ack_o(sack[1]), .s_err_o(serr[1]),
        .m_cyc_o(mcyc[1]), .m_stb_o(mstb[1]), .m_we_o(mwe[1]), .m_adr_o(madr[1]), .m_dat_o(mdo[1]),
        .m_sel_o(msel[1]), .m_dat_i(mdi[1]), .m_ack_i(mack[1]),
        .grant_o(gnt[1]), .debug_state(dst[1]));

    // SDRAM stand-in: acks three cycles after STB is seen, unless stalled.
    logic [15:0] mem [2][256];
    int          scnt[2];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                mack[d] <= 1'b0;
                mdi[d]  <= '0;
                scnt[d] <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                mack[d] <= 1'b0;
                if (mcyc[d] && mstb[d] && !mack[d] && !stall[d]) begin
                    if (scnt[d] == 2) begin
                        mack[d] <= 1'b1;
                        scnt[d] <= 0;
                        if (mwe[d]) mem[d][madr[d][7:0]] <= mdo[d];
                        else        mdi[d] <= mem[d][madr[d][7:0]];
                    end else begin
                        scnt[d] <= scnt[d] + 1;
                    end
                end
            end
        end
    end

    typedef struct {
        int          port;
        logic        err;
        logic        chk;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [3:0] mon_ack, mon_err;
    int   checks   = 0;
    int   failures = 0;
    int   dsel     = 0;

    task automatic push(input int p, input logic e, input logic c, input logic [15:0] d);
        exp_t x;
        x.port = p; x.err = e; x.chk = c; x.data = d;
        sb.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (sack[dsel] != 4'b0 || serr[dsel] != 4'b0)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_resp ack=%b err=%b required=none", sack[dsel], serr[dsel]);
            end else begin
                mon_e   = sb.pop_front();
                mon_ack = mon_e.err ? 4'b0000 : (4'b0001 << mon_e.port);
                mon_err = mon_e.err ? (4'b0001 << mon_e.port) : 4'b0000;
                if (sack[dsel] !== mon_ack || serr[dsel] !== mon_err) begin
                    failures++;
                    $display("FAIL resp_port ack=%b err=%b required_ack=%b required_err=%b",
                             sack[dsel], serr[dsel], mon_ack, mon_err);
                end else if (mon_e.chk && sdo[dsel][mon_e.port*16 +: 16] !== mon_e.data) begin
                    failures++;
                    $display("FAIL resp_data port=%0d actual=%h required=%h",
                             mon_e.port, sdo[dsel][mon_e.port*16 +: 16], mon_e.data);
                end
            end
        end
    end

    task automatic wait_resp(input int p);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(sack[dsel][p] || serr[dsel][p]) && t < 200);
        if (!(sack[dsel][p] || serr[dsel][p])) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout port=%0d actual=none required=ack_or_err", p);
        end
    endtask

    task automatic master(input int p, input int n, input bit hold, input bit w,
                          input logic [23:0] a, input logic [15:0] d, input int gap);
        for (int k = 0; k < n; k++) begin
            cyc[p] = 1'b1; stb[p] = 1'b1; we[p] = w;
            adr[p] = a + 24'(k); wdat[p] = d + 16'(k);
            wait_resp(p);
            stb[p] = 1'b0;
            if (!hold || k == n - 1) cyc[p] = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk(name, sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int p = 0; p < 4; p++) begin
            cyc[p] = 1'b0; stb[p] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int cnt;
        for (int p = 0; p < 4; p++) begin
            cyc[p] = 1'b0; stb[p] = 1'b0; we[p] = 1'b0; adr[p] = '0; wdat[p] = '0;
        end
        stall[0] = 1'b0; stall[1] = 1'b0;
        do_reset();
        chk("reset_grant", gnt[0], 0);
        chk("reset_state", dst[0], 0);
        chk("reset_mcyc", {mcyc[0], mstb[0]}, 0);
        chk("reset_sdat", sdo[0][31:0], 0);

        // Write then read back through port 0.
        push(0, 0, 0, 16'h0); push(0, 0, 1, 16'hABCD);
        master(0, 1, 0, 1, 24'h000100, 16'hABCD, 1);
        master(0, 1, 0, 0, 24'h000100, 16'h0, 1);
        drain("t1_drain");

        // All four ports, two single accesses each: strict rotation.
        do_reset();
        for (int r = 0; r < 2; r++) for (int p = 0; p < 4; p++) push(p, 0, 0, 16'h0);
        fork
            master(0, 2, 0, 1, 24'h10, 16'h1000, 1);
            master(1, 2, 0, 1, 24'h20, 16'h2000, 1);
            master(2, 2, 0, 1, 24'h30, 16'h3000, 1);
            master(3, 2, 0, 1, 24'h40, 16'h4000, 1);
        join
        push(2, 0, 1, 16'h4000); push(2, 0, 1, 16'h4001);
        master(2, 2, 1, 0, 24'h40, 16'h0, 0);
        drain("t2_drain");

        // Fixed priority: port 0 streams 10 with CYC held; port 3 only after it lets go.
        dsel = 1;
        do_reset();
        for (int k = 0; k < 10; k++) push(0, 0, 0, 16'h0);
        push(3, 0, 0, 16'h0);
        fork
            master(0, 10, 1, 1, 24'h80, 16'h8000, 0);
            master(3, 1, 0, 0, 24'h90, 16'h0, 1);
        join
        drain("t3_drain");
        dsel = 0;

        // Lock limit: port 1 gets 8, port 2 one, port 1 the remaining 2.
        do_reset();
        for (int k = 0; k < 8; k++) push(1, 0, 0, 16'h0);
        push(2, 0, 0, 16'h0);
        for (int k = 0; k < 2; k++) push(1, 0, 0, 16'h0);
        fork
            master(1, 10, 1, 1, 24'h50, 16'h5000, 0);
            master(2, 1, 0, 1, 24'h60, 16'h6000, 1);
        join
        drain("t4_drain");

        // Hold window expiry hands the bus to the pending port.
        do_reset();
        push(0, 0, 0, 16'h0); push(3, 0, 0, 16'h0);
        fork
            begin
                cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 24'h10;
                wait_resp(0);
                stb[0] = 1'b0;
                @(negedge clk);       chk("t5_hold_enter", dst[0], 3);
                repeat (3) @(negedge clk); chk("t5_hold_still", dst[0], 3);
                @(negedge clk);       chk("t5_hold_release", dst[0], 0);
                @(negedge clk);       chk("t5_pending_grant", gnt[0], 4'b1000);
                cyc[0] = 1'b0;
            end
            master(3, 1, 0, 0, 24'h20, 16'h0, 1);
        join
        drain("t5_drain");

        // Ack timeout with a stalled slave.
        do_reset();
        stall[0] = 1'b1;
        push(2, 1, 0, 16'h0);
        fork
            master(2, 1, 0, 0, 24'h30, 16'h0, 1);
            begin
                cnt = 0;
                while (!mstb[0] && cnt < 10) begin @(negedge clk); cnt++; end
                chk("t6_mstb_rise", mstb[0], 1);
                cnt = 0;
                while (!serr[0][2] && cnt < 40) begin @(negedge clk); cnt++; end
                chk("t6_err_cycles", cnt, 16);
                chk("t6_mcyc_dropped", mcyc[0], 0);
                @(negedge clk);
                chk("t6_back_idle", dst[0], 0);
            end
        join
        stall[0] = 1'b0;
        drain("t6_drain");

        // Async reset while BUSY, then rotation restarts at port 0.
        do_reset();
        stall[0] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 24'h11;
        cnt = 0;
        while (!mstb[0] && cnt < 10) begin @(negedge clk); cnt++; end
        chk("t7_busy", dst[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_mcyc", {mcyc[0], mstb[0]}, 0);
        chk("t7_rst_grant", gnt[0], 0);
        chk("t7_rst_state", dst[0], 0);
        chk("t7_rst_ack", {sack[0], serr[0]}, 0);
        cyc[1] = 1'b0; stb[1] = 1'b0; stall[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int p = 0; p < 4; p++) push(p, 0, 0, 16'h0);
        fork
            master(0, 1, 0, 0, 24'h01, 16'h0, 1);
            master(1, 1, 0, 0, 24'h02, 16'h0, 1);
            master(2, 1, 0, 0, 24'h03, 16'h0, 1);
            master(3, 1, 0, 0, 24'h04, 16'h0, 1);
        join
        drain("t7_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
